// File: rtl/sbox_round_scheduler.sv
// Drives a 48-bit key-mixed half-block through one shared DES S-box port, 6 bits per cycle,
// and assembles the 32-bit result. Define SBOX_SCHED_ABORT_EN to add the wAbort input.
module sbox_round_scheduler #(
  parameter int SBOX_LAT = 0
) (
  input  logic        wClk,
  input  logic        wReset,
  input  logic [47:0] wInData,
  input  logic        wInValid,
  output logic        wInReady,
  output logic [2:0]  wSboxSel,
  output logic [5:0]  wSboxIn,
  input  logic [3:0]  wSboxOut,
`ifdef SBOX_SCHED_ABORT_EN
  input  logic        wAbort,
`endif
  output logic [31:0] wOutData,
  output logic        wOutValid,
  input  logic        wOutReady,
  output logic        wBusy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(7 + SBOX_LAT);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg;
  logic [2:0]  sel_reg;
  logic [5:0]  chunk_reg;
  logic [41:0] rest_reg;
  logic [31:0] res_reg, res_next, out_reg;
  logic        cap_en;
  logic [2:0]  cap_idx;
  logic        accept, abort_run, last_cycle, in_run;

  assign in_run     = (state_reg == RUN);
  assign accept     = (state_reg == IDLE) && wInValid;
  assign last_cycle = (cnt_reg == LAST_CNT);

`ifdef SBOX_SCHED_ABORT_EN
  assign abort_run = in_run && wAbort;
`else
  assign abort_run = 1'b0;
`endif

  // Lookup result for issue k arrives SBOX_LAT cycles after it, so capture lags issue.
  if (SBOX_LAT == 0) begin : g_lat0
    assign cap_en  = 1'b1;
    assign cap_idx = cnt_reg[2:0];
  end else begin : g_lat1
    assign cap_en  = (cnt_reg != 4'd0);
    assign cap_idx = 3'(cnt_reg - 4'd1);
  end

  genvar gi;
  for (gi = 0; gi < 8; gi++) begin : g_nib
    assign res_next[31-4*gi -: 4] = (in_run && cap_en && (cap_idx == 3'(gi))) ?
                                    wSboxOut : res_reg[31-4*gi -: 4];
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: if (wInValid) state_next = RUN;
      RUN: begin
        if (abort_run)       state_next = IDLE;
        else if (last_cycle) state_next = DONE;
      end
      DONE: if (wOutReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wClk) begin
    if (wReset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge wClk) begin
    if (wReset) begin
      cnt_reg   <= '0;
      sel_reg   <= '0;
      chunk_reg <= '0;
      rest_reg  <= '0;
      res_reg   <= '0;
      out_reg   <= '0;
    end else if (accept) begin
      cnt_reg   <= '0;
      sel_reg   <= '0;
      chunk_reg <= wInData[47:42];
      rest_reg  <= wInData[41:0];
      res_reg   <= '0;
    end else if (in_run) begin
      cnt_reg <= cnt_reg + 4'd1;
      res_reg <= res_next;
      // Once S8 is issued, sel/in stay put until the last capture.
      if (sel_reg != 3'd7) begin
        sel_reg   <= sel_reg + 3'd1;
        chunk_reg <= rest_reg[41:36];
        rest_reg  <= {rest_reg[35:0], 6'b0};
      end
      if (last_cycle && !abort_run) out_reg <= res_next;
    end
  end

  assign wInReady  = (state_reg == IDLE);
  assign wBusy     = (state_reg != IDLE);
  assign wOutValid = (state_reg == DONE);
  assign wOutData  = out_reg;
  assign wSboxSel  = sel_reg;
  assign wSboxIn   = chunk_reg;

endmodule

// File: tb/tb_sbox_round_scheduler.sv
// Scoreboard bench: two lanes (SBOX_LAT 0 and 1) driven by a golden DES S1..S8 model.
`timescale 1ns/1ps
module tb_sbox_round_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  int sbox_tab [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,     0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,     15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,     3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,     13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,     13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,     1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,     13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,     3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,     14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,     11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,     10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,     4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,     13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,     6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,     1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,     2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11
  };

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  function automatic logic [3:0] sb(input int s, input logic [5:0] x);
    int r, c;
    r = 2 * int'(x[5]) + int'(x[0]);
    c = int'(x[4:1]);
    return 4'(sbox_tab[s*64 + r*16 + c]);
  endfunction

  function automatic logic [31:0] model(input logic [47:0] x);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r = {r[27:0], sb(k, x[47-6*k -: 6])};
    return r;
  endfunction

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_lane
    localparam int L = gi;

    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [47:0] in_data   = '0;
`ifdef SBOX_SCHED_ABORT_EN
    logic        abort     = 1'b0;
`endif
    logic        in_ready, out_valid, busy;
    logic [2:0]  sel;
    logic [5:0]  sin;
    logic [3:0]  sout;
    logic [31:0] out_data;

    exp_t        q[$];
    exp_t        e_push, e_pop;
    int          acc_cnt  = 0;
    int          last_acc = 0;
    logic [31:0] last_exp = '0;
    logic [31:0] held     = '0;
    logic        prev_v   = 1'b0;
    bit          rand_ready = 1'b0;
    bit          done_l   = 1'b0;

    sbox_round_scheduler #(.SBOX_LAT(L)) u_dut (
      .wClk(clk), .wReset(rst), .wInData(in_data), .wInValid(in_valid), .wInReady(in_ready),
      .wSboxSel(sel), .wSboxIn(sin), .wSboxOut(sout),
`ifdef SBOX_SCHED_ABORT_EN
      .wAbort(abort),
`endif
      .wOutData(out_data), .wOutValid(out_valid), .wOutReady(out_ready), .wBusy(busy)
    );

    if (L == 0) begin : g_comb
      always_comb sout = sb(int'(sel), sin);
    end else begin : g_reg
      always @(posedge clk) sout <= sb(int'(sel), sin);
    end

    task automatic chk(input string name, input logic [47:0] got, input logic [47:0] want);
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL lane%0d %s: got %0h need %0h", L, name, got, want);
      end
    endtask

    task automatic wait_acc();
      int n, t;
      n = acc_cnt;
      t = 0;
      while (acc_cnt == n && t < 100) begin
        @(negedge clk);
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        t++;
      end
      chk("accept_in_time", 48'(acc_cnt != n), 48'(1));
    endtask

    task automatic wait_drain();
      int t;
      t = 0;
      while ((q.size() != 0 || out_valid) && t < 300) begin
        @(negedge clk);
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        t++;
      end
      chk("drain_in_time", 48'(q.size() != 0 || out_valid), 48'(0));
    endtask

    // Observer: any real handshake (pre-edge values) queues the model's answer.
    initial forever begin
      @(posedge clk);
      if (!rst && in_valid && in_ready) begin
        e_push.d = model(in_data);
        e_push.c = cyc;
        q.push_back(e_push);
        last_acc = cyc;
        acc_cnt++;
      end
    end

    // Monitor: compares every result as it is presented.
    initial forever begin
      @(negedge clk);
      if (out_valid && !prev_v) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL lane%0d spurious_valid: got out_valid=1 need 0 (no block pending)", L);
        end else begin
          e_pop = q.pop_front();
          chk("result", 48'(out_data), 48'(e_pop.d));
          chk("latency", 48'(cyc - e_pop.c), 48'(9 + L));
          last_exp = e_pop.d;
          held     = out_data;
        end
      end else if (out_valid) begin
        chk("stable_data", 48'(out_data), 48'(held));
      end
      if (out_valid) chk("in_ready_in_done", 48'(in_ready), 48'(0));
      prev_v = out_valid;
    end

    initial begin
      int prev;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_in_ready", 48'(in_ready), 48'(1));
      chk("rst_out_valid", 48'(out_valid), 48'(0));
      chk("rst_out_data", 48'(out_data), 48'(0));
      chk("rst_sel", 48'(sel), 48'(0));
      chk("rst_sin", 48'(sin), 48'(0));
      chk("rst_busy", 48'(busy), 48'(0));

      // Directed corner blocks.
      out_ready = 1'b1;
      in_data = '0;  in_valid = 1'b1; wait_acc(); in_valid = 1'b0; wait_drain();
      in_data = '1;  in_valid = 1'b1; wait_acc(); in_valid = 1'b0; wait_drain();

      // Backpressure in DONE with ignored input pulses.
      out_ready = 1'b0;
      in_data = 48'({$urandom(), $urandom()}); in_valid = 1'b1; wait_acc(); in_valid = 1'b0;
      for (int t = 0; t < 40 && !out_valid; t++) @(negedge clk);
      chk("bp_valid_seen", 48'(out_valid), 48'(1));
      repeat (5) begin
        @(negedge clk);
        chk("bp_hold_valid", 48'(out_valid), 48'(1));
        chk("bp_in_ready", 48'(in_ready), 48'(0));
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 48'({$urandom(), $urandom()});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", 48'(out_valid), 48'(0));
      chk("bp_release_ready", 48'(in_ready), 48'(1));
      wait_drain();

      // Continuous alternating stream; throughput from accept spacing.
      prev = 0;
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
        in_data = (i % 2 == 1) ? '1 : '0;
        wait_acc();
        if (i > 0) chk("throughput", 48'(last_acc - prev), 48'(10 + L));
        prev = last_acc;
      end
      in_valid = 1'b0;
      wait_drain();

      // Reset during RUN at issue k=4.
      in_data = 48'({$urandom(), $urandom()}); in_valid = 1'b1; wait_acc(); in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      q.delete();
      @(negedge clk);
      chk("rst_run_valid", 48'(out_valid), 48'(0));
      chk("rst_run_data", 48'(out_data), 48'(0));
      chk("rst_run_ready", 48'(in_ready), 48'(1));
      rst = 1'b0;
      in_data = '0; in_valid = 1'b1; wait_acc(); in_valid = 1'b0; wait_drain();

`ifdef SBOX_SCHED_ABORT_EN
      // Abort at issue k=3 keeps the previous result.
      in_data = 48'({$urandom(), $urandom()}); in_valid = 1'b1; wait_acc(); in_valid = 1'b0;
      repeat (3) @(negedge clk);
      abort = 1'b1;
      q.delete();
      @(negedge clk);
      abort = 1'b0;
      chk("abort_ready", 48'(in_ready), 48'(1));
      chk("abort_data", 48'(out_data), 48'(last_exp));
      chk("abort_busy", 48'(busy), 48'(0));
      repeat (12) @(negedge clk);
`endif

      // Random blocks, random gaps, random consumer stalls.
      rand_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
        in_data = 48'({$urandom(), $urandom()});
        in_valid = 1'b1;
        wait_acc();
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      rand_ready = 1'b0;
      out_ready = 1'b1;
      wait_drain();
      done_l = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(g_lane[0].done_l && g_lane[1].done_l) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (!(g_lane[0].done_l && g_lane[1].done_l)) begin
      total++;
      bad++;
      $display("FAIL global_timeout: got lanes done=%b%b need 11", g_lane[1].done_l, g_lane[0].done_l);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
